// File: rtl/hilo_muldiv_sched.sv
// HILO sequencer: launches mul/div, stalls EX until the result is back,
// then writes HI/LO. Ports: pipeline ctl, mul/div handshake, HILO write.
module hilo_muldiv_sched #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid_e,
  input  logic [7:0]  aluop_e,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush_e,
  output logic        stall_e,
  output logic        busy,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        mul_start,
  output logic        mul_signed,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  input  logic        div_done,
  input  logic [63:0] div_result,
  output logic        div_cancel,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata
);

  localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
  localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] OP_DIV   = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU  = 8'b0001_1011;

  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL_WAIT,
    DIV_WAIT,
    WRITE
  } state_t;

  state_t      state;
  state_t      nxt;
  logic [3:0]  cnt;
  logic [63:0] res;
  logic        go;
  logic        is_mul;
  logic        is_div;
  logic        is_mf;
  logic        cap_mul;
  logic        cap_div;

  assign go     = op_valid_e & ~flush_e;
  assign is_mul = (aluop_e == OP_MULT) | (aluop_e == OP_MULTU);
  assign is_div = (aluop_e == OP_DIV) | (aluop_e == OP_DIVU);
  assign is_mf  = (aluop_e == OP_MFHI) | (aluop_e == OP_MFLO);
  assign busy   = (state != IDLE);

  // Strobes are held low while reset is asserted, whatever the inputs.
  always_comb begin
    nxt        = state;
    stall_e    = 1'b0;
    mul_start  = 1'b0;
    div_start  = 1'b0;
    div_cancel = 1'b0;
    hi_we      = 1'b0;
    lo_we      = 1'b0;
    hi_wdata   = 32'd0;
    lo_wdata   = 32'd0;
    cap_mul    = 1'b0;
    cap_div    = 1'b0;
    if (resetn) begin
      unique case (state)
        IDLE: begin
          if (go) begin
            unique case (1'b1)
              is_mul: begin
                mul_start = 1'b1;
                stall_e   = 1'b1;
                nxt       = MUL_WAIT;
              end
              is_div: begin
                // Divide by zero passes through untouched.
                if (src_b != 32'd0) begin
                  div_start = 1'b1;
                  stall_e   = 1'b1;
                  nxt       = DIV_WAIT;
                end
              end
              (aluop_e == OP_MTHI): begin
                hi_we    = 1'b1;
                hi_wdata = src_a;
              end
              (aluop_e == OP_MTLO): begin
                lo_we    = 1'b1;
                lo_wdata = src_a;
              end
              default: ;
            endcase
          end
        end
        MUL_WAIT: begin
          if (flush_e) begin
            nxt = IDLE;
          end else begin
            stall_e = 1'b1;
            if (cnt == 4'd0) begin
              cap_mul = 1'b1;
              nxt     = WRITE;
            end
          end
        end
        DIV_WAIT: begin
          if (flush_e) begin
            div_cancel = 1'b1;
            nxt        = IDLE;
          end else begin
            stall_e = 1'b1;
            if (div_done) begin
              cap_div = 1'b1;
              nxt     = WRITE;
            end
          end
        end
        WRITE: begin
          nxt = IDLE;
          if (!flush_e) begin
            hi_we    = 1'b1;
            lo_we    = 1'b1;
            hi_wdata = res[63:32];
            lo_wdata = res[31:0];
          end
        end
        default: nxt = IDLE;
      endcase
      // MFHI/MFLO must not read HILO while a write is pending.
      if (is_mf && op_valid_e && !flush_e &&
          (state == MUL_WAIT || state == DIV_WAIT))
        stall_e = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      op_a       <= 32'd0;
      op_b       <= 32'd0;
      mul_signed <= 1'b0;
      div_signed <= 1'b0;
      res        <= 64'd0;
    end else begin
      state <= nxt;
      if (mul_start) begin
        op_a       <= src_a;
        op_b       <= src_b;
        mul_signed <= (aluop_e == OP_MULT);
        cnt        <= CNT_INIT;
      end
      if (div_start) begin
        op_a       <= src_a;
        op_b       <= src_b;
        div_signed <= (aluop_e == OP_DIV);
      end
      if (state == MUL_WAIT && cnt != 4'd0)
        cnt <= cnt - 4'd1;
      if (cap_mul)
        res <= mul_result;
      if (cap_div)
        res <= div_result;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_sched.sv
// Directed bench for hilo_muldiv_sched; the bench plays the role of
// the multiplier (fixed latency) and the divider (manual div_done).
module tb_hilo_muldiv_sched;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] OP_DIV   = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU  = 8'b0001_1011;
  localparam logic [63:0] JUNK    = 64'hBAD0_BAD0_BAD0_BAD0;

  logic        clk = 1'b0;
  logic        resetn;
  logic        op_valid_e;
  logic [7:0]  aluop_e;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush_e;
  logic        stall_e;
  logic        busy;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        mul_start;
  logic        mul_signed;
  logic [63:0] mul_result;
  logic        div_start;
  logic        div_signed;
  logic        div_done;
  logic [63:0] div_result;
  logic        div_cancel;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;

  int total = 0;
  int bad = 0;

  logic [63:0] mul_model;
  logic [1:0]  ms_q = 2'b00;

  hilo_muldiv_sched #(.MUL_LAT(2)) dut (
    .clk(clk), .resetn(resetn),
    .op_valid_e(op_valid_e), .aluop_e(aluop_e),
    .src_a(src_a), .src_b(src_b), .flush_e(flush_e),
    .stall_e(stall_e), .busy(busy),
    .op_a(op_a), .op_b(op_b),
    .mul_start(mul_start), .mul_signed(mul_signed),
    .mul_result(mul_result),
    .div_start(div_start), .div_signed(div_signed),
    .div_done(div_done), .div_result(div_result),
    .div_cancel(div_cancel),
    .hi_we(hi_we), .lo_we(lo_we),
    .hi_wdata(hi_wdata), .lo_wdata(lo_wdata)
  );

  always #5 clk = ~clk;

  // Multiplier model: product valid only exactly 2 cycles after start.
  always @(posedge clk) ms_q <= {ms_q[0], mul_start};
  assign mul_result = ms_q[1] ? mul_model : JUNK;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [7:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    op_valid_e = v;
    aluop_e    = op;
    src_a      = a;
    src_b      = b;
  endtask

  initial begin
    resetn = 1'b0;
    drive(1'b0, OP_NOP, 32'd0, 32'd0);
    flush_e    = 1'b0;
    div_done   = 1'b0;
    div_result = JUNK;
    mul_model  = JUNK;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall_e, 0);
    chk("rst_opa", op_a, 0);
    chk("rst_sign", {mul_signed, div_signed}, 0);
    #1 resetn = 1'b1;

    // MULT -2 * 3
    cyc();
    mul_model = 64'hFFFF_FFFF_FFFF_FFFA;
    drive(1'b1, OP_MULT, 32'hFFFF_FFFE, 32'd3);
    #1;
    chk("mul_start", mul_start, 1);
    chk("mul_stall0", stall_e, 1);
    cyc(); #1;
    chk("mul_start_pulse", mul_start, 0);
    chk("mul_stall1", stall_e, 1);
    chk("mul_signed", mul_signed, 1);
    chk("mul_ops", {op_a, op_b}, 64'hFFFF_FFFE_0000_0003);
    cyc(); #1;
    chk("mul_stall2", stall_e, 1);
    chk("mul_nowe", {hi_we, lo_we}, 0);
    cyc(); #1;
    chk("mul_we", {hi_we, lo_we}, 2'b11);
    chk("mul_data", {hi_wdata, lo_wdata}, 64'hFFFF_FFFF_FFFF_FFFA);
    chk("mul_wr_stall", stall_e, 0);
    chk("mul_b2b", mul_start, 0);
    cyc();
    drive(1'b0, OP_NOP, 32'd0, 32'd0);
    #1;
    chk("mul_idle", busy, 0);

    // DIVU 100 / 7, div_done 10 cycles after start
    cyc();
    drive(1'b1, OP_DIVU, 32'd100, 32'd7);
    #1;
    chk("divu_start", div_start, 1);
    chk("divu_stall0", stall_e, 1);
    cyc(); #1;
    chk("divu_pulse", div_start, 0);
    chk("divu_signed", div_signed, 0);
    repeat (8) cyc();
    #1;
    chk("divu_stall9", stall_e, 1);
    cyc();
    div_done   = 1'b1;
    div_result = {32'd2, 32'd14};
    #1;
    chk("divu_stall10", stall_e, 1);
    chk("divu_nowe", hi_we, 0);
    cyc();
    div_done   = 1'b0;
    div_result = JUNK;
    #1;
    chk("divu_we", {hi_we, lo_we}, 2'b11);
    chk("divu_data", {hi_wdata, lo_wdata}, {32'd2, 32'd14});
    chk("divu_wr_stall", stall_e, 0);
    chk("divu_wr_busy", busy, 1);
    cyc();
    drive(1'b0, OP_NOP, 32'd0, 32'd0);
    div_done = 1'b1;
    #1;
    chk("divu_idle", busy, 0);
    cyc();
    div_done = 1'b0;
    #1;
    chk("done_in_idle", busy, 0);

    // DIV by zero passes through
    cyc();
    drive(1'b1, OP_DIV, 32'd5, 32'd0);
    #1;
    chk("dz_start", div_start, 0);
    chk("dz_stall", stall_e, 0);
    chk("dz_we", {hi_we, lo_we}, 0);
    cyc();
    drive(1'b1, OP_MTLO, 32'h1234_5678, 32'd0);
    #1;
    chk("dz_busy", busy, 0);

    // MTLO same cycle write
    chk("mtlo_we", {hi_we, lo_we}, 2'b01);
    chk("mtlo_data", lo_wdata, 32'h1234_5678);
    chk("mtlo_stall", stall_e, 0);
    cyc();
    drive(1'b1, OP_MTHI, 32'hCAFE_0001, 32'd0);
    flush_e = 1'b1;
    #1;
    chk("mthi_flush", hi_we, 0);
    flush_e = 1'b0;
    #1;
    chk("mthi_we", {hi_we, hi_wdata}, 33'h1_CAFE_0001);

    // DIV 20/3, flushed in DIV_WAIT with colliding div_done
    cyc();
    drive(1'b1, OP_DIV, 32'd20, 32'd3);
    #1;
    chk("div_start", div_start, 1);
    cyc();
    drive(1'b1, OP_MFHI, 32'd0, 32'd0);
    #1;
    chk("div_signed", div_signed, 1);
    chk("mf_interlock", stall_e, 1);
    cyc();
    flush_e    = 1'b1;
    div_done   = 1'b1;
    div_result = {32'd2, 32'd6};
    #1;
    chk("fl_cancel", div_cancel, 1);
    chk("fl_stall", stall_e, 0);
    chk("fl_we", {hi_we, lo_we}, 0);
    cyc();
    flush_e  = 1'b0;
    div_done = 1'b0;
    #1;
    chk("fl_idle", busy, 0);
    chk("fl_cancel_pulse", div_cancel, 0);
    chk("mf_idle_nostall", stall_e, 0);
    cyc();
    drive(1'b0, OP_NOP, 32'd0, 32'd0);
    div_done = 1'b1;
    #1;
    chk("late_done_we", {hi_we, lo_we}, 0);
    cyc();
    div_done = 1'b0;
    #1;
    chk("late_done_busy", busy, 0);

    // MULT 2*3 flushed in WRITE
    cyc();
    mul_model = 64'd6;
    drive(1'b1, OP_MULT, 32'd2, 32'd3);
    repeat (3) cyc();
    flush_e = 1'b1;
    #1;
    chk("wrfl_busy", busy, 1);
    chk("wrfl_we", {hi_we, lo_we}, 0);
    cyc();
    flush_e = 1'b0;
    drive(1'b0, OP_NOP, 32'd0, 32'd0);
    #1;
    chk("wrfl_idle", busy, 0);

    // Reset in MUL_WAIT, then MULTU 5*6
    cyc();
    mul_model = JUNK;
    drive(1'b1, OP_MULT, 32'd7, 32'd8);
    cyc(); #1;
    chk("rmid_busy", busy, 1);
    resetn = 1'b0;
    #1;
    chk("rmid_busy0", busy, 0);
    chk("rmid_stall0", stall_e, 0);
    chk("rmid_ops0", {op_a, op_b}, 0);
    chk("rmid_sign0", mul_signed, 0);
    cyc();
    resetn    = 1'b1;
    mul_model = 64'd30;
    drive(1'b1, OP_MULTU, 32'd5, 32'd6);
    #1;
    chk("rel_start", mul_start, 1);
    repeat (3) cyc();
    #1;
    chk("rel_we", {hi_we, lo_we}, 2'b11);
    chk("rel_data", {hi_wdata, lo_wdata}, 64'd30);
    chk("rel_unsigned", mul_signed, 0);
    cyc();
    drive(1'b0, OP_NOP, 32'd0, 32'd0);
    #1;
    chk("rel_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
